hwpe_stream_sink_checker: RTL and testbench

Synthesizable consumer end of an hwpe_stream link, used in streamer and accelerator benches and on-chip self-test. It drives pseudo-random backpressure on ready. It checks every accepted beat against an internally regenerated LFSR data sequence, honouring strb. It reports beat count, error count and the first mismatch.

---
 rtl/hwpe_stream_sink_checker_if.sv | 26 ++
 rtl/hwpe_stream_sink_checker.sv | 231 +++++++++++++++++++++++
 tb/tb_hwpe_stream_sink_checker.sv | 417 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hwpe_stream_sink_checker_if.sv
// -----------------------------------------------------------------------------
// hwpe_stream_intf_stream
//
// Minimal hwpe_stream link: one beat per valid & ready handshake.
//
// Signals:
//   valid  source -> sink   beat present on data/strb
//   ready  sink   -> source sink accepts the beat this cycle
//   data   source -> sink   DATA_WIDTH-bit payload
//   strb   source -> sink   one enable bit per payload byte
// -----------------------------------------------------------------------------
interface hwpe_stream_intf_stream #(
    parameter int unsigned DATA_WIDTH = 32
) ();

    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

    logic                  valid;
    logic                  ready;
    logic [DATA_WIDTH-1:0] data;
    logic [STRB_WIDTH-1:0] strb;

    modport source (output valid, output data, output strb, input ready);
    modport sink   (input valid, input data, input strb, output ready);

endinterface

// File: rtl/hwpe_stream_sink_checker.sv
// -----------------------------------------------------------------------------
// hwpe_stream_sink_checker
//
// Consumer end of an hwpe_stream link for benches and on-chip self-test.
// Drives pseudo-random backpressure on ready, regenerates the expected data
// sequence from an LFSR and checks every accepted beat against it (only bytes
// with strb set are compared). Reports beat count, error count and the first
// mismatching beat.
//
// Ports:
//   clk_i             clock
//   rst_ni            asynchronous active-low reset
//   clear_i           synchronous soft clear, same values as reset
//   enable_i          run request (IDLE <-> RUN)
//   force_ready_i     ready forced high while in RUN
//   expected_beats_i  beats to check before DONE, 0 = unlimited
//   data_i            checked stream (sink side)
//   beat_cnt_o        accepted beats (saturating)
//   err_cnt_o         mismatching beats (saturating)
//   err_o             sticky error flag
//   first_err_idx_o   beat index of the first mismatch
//   first_err_data_o  received data of the first mismatch
//   done_o            high in DONE
// -----------------------------------------------------------------------------
module hwpe_stream_sink_checker #(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned STALL_THRESH = 0,
    parameter logic [31:0] DATA_SEED    = 32'hACE1_2468,
    parameter logic [15:0] BP_SEED      = 16'hB5A3
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  clear_i,
    input  logic                  enable_i,
    input  logic                  force_ready_i,
    input  logic [31:0]           expected_beats_i,
    hwpe_stream_intf_stream.sink  data_i,
    output logic [31:0]           beat_cnt_o,
    output logic [31:0]           err_cnt_o,
    output logic                  err_o,
    output logic [31:0]           first_err_idx_o,
    output logic [DATA_WIDTH-1:0] first_err_data_o,
    output logic                  done_o
);

    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
    localparam logic [31:0] DATA_TAPS  = 32'h8020_0003;
    localparam logic [15:0] BP_TAPS    = 16'hB400;
    localparam logic [31:0] LANE_STEP  = 32'h9E37_79B9;
    localparam logic [31:0] CNT_MAX    = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic [31:0]           data_lfsr_q, data_lfsr_d;
    logic [15:0]           bp_lfsr_q, bp_lfsr_d;
    logic [31:0]           beat_cnt_q, beat_cnt_d;
    logic [31:0]           err_cnt_q, err_cnt_d;
    logic                  err_q, err_d;
    logic [31:0]           first_err_idx_q, first_err_idx_d;
    logic [DATA_WIDTH-1:0] first_err_data_q, first_err_data_d;
    logic                  done_q, done_d;

    logic                  bp_pass;
    logic                  ready;
    logic                  handshake;
    logic                  mismatch;
    logic [31:0]           lane_word;
    logic                  target_set;
    logic                  target_hit;
    logic                  target_passed;

    // Galois LFSRs, right shifting: feed the shifted-out bit back through taps.
    function automatic logic [31:0] data_lfsr_step(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? DATA_TAPS : 32'h0);
    endfunction

    function automatic logic [15:0] bp_lfsr_step(input logic [15:0] s);
        return (s >> 1) ^ (s[0] ? BP_TAPS : 16'h0);
    endfunction

    // ------------------------------------------------------------------------
    // Backpressure. Ready depends only on flops and force_ready_i, so there is
    // no combinational path from valid back to ready.
    // ------------------------------------------------------------------------
    assign bp_pass      = 32'(bp_lfsr_q[7:0]) >= STALL_THRESH;
    assign ready        = (state_q == RUN) & (bp_pass | force_ready_i);
    assign data_i.ready = ready;
    assign handshake    = data_i.valid & ready;

    // ------------------------------------------------------------------------
    // Beat compare. Expected word is built from 32-bit lanes, lane j being
    // data_lfsr ^ (j * LANE_STEP); a trailing partial lane uses its low bytes.
    // ------------------------------------------------------------------------
    // NOTE: every variable written in an always_comb gets a default before any
    // conditional assignment; otherwise synthesis infers a latch for it.
    always_comb begin
        lane_word = '0;
        mismatch  = 1'b0;
        for (int b = 0; b < STRB_WIDTH; b++) begin
            lane_word = data_lfsr_q ^ (32'(b / 4) * LANE_STEP);
            if (data_i.strb[b] &&
                (data_i.data[b*8 +: 8] != lane_word[(b % 4)*8 +: 8])) begin
                mismatch = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Completion: the accepting beat reaches the target, or the target was
    // lowered below the count already reached.
    // ------------------------------------------------------------------------
    assign target_set    = expected_beats_i != 32'd0;
    assign target_hit    = handshake && (beat_cnt_d == expected_beats_i);
    assign target_passed = beat_cnt_q > expected_beats_i;

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d          = state_q;
        data_lfsr_d      = data_lfsr_q;
        bp_lfsr_d        = bp_lfsr_q;
        beat_cnt_d       = beat_cnt_q;
        err_cnt_d        = err_cnt_q;
        err_d            = err_q;
        first_err_idx_d  = first_err_idx_q;
        first_err_data_d = first_err_data_q;

        unique case (state_q)
            IDLE: begin
                if (enable_i) begin
                    state_d = RUN;
                end
            end

            RUN: begin
                // Backpressure pattern runs freely, independent of traffic.
                bp_lfsr_d = bp_lfsr_step(bp_lfsr_q);

                if (handshake) begin
                    data_lfsr_d = data_lfsr_step(data_lfsr_q);
                    if (beat_cnt_q != CNT_MAX) begin
                        beat_cnt_d = beat_cnt_q + 32'd1;
                    end
                    if (mismatch) begin
                        err_d = 1'b1;
                        if (err_cnt_q != CNT_MAX) begin
                            err_cnt_d = err_cnt_q + 32'd1;
                        end
                        if (err_cnt_q == 32'd0) begin
                            first_err_idx_d  = beat_cnt_q;
                            first_err_data_d = data_i.data;
                        end
                    end
                end

                // Completion outranks a falling enable; the beat is counted
                // either way.
                if (target_set && (target_hit || target_passed)) begin
                    state_d = DONE;
                end else if (!enable_i) begin
                    state_d = IDLE;
                end
            end

            DONE: begin
                state_d = DONE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // Soft clear wins over everything, including a concurrent handshake.
        if (clear_i) begin
            state_d          = IDLE;
            data_lfsr_d      = DATA_SEED;
            bp_lfsr_d        = BP_SEED;
            beat_cnt_d       = '0;
            err_cnt_d        = '0;
            err_d            = 1'b0;
            first_err_idx_d  = '0;
            first_err_data_d = '0;
        end

        done_d = (state_d == DONE);
    end

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q          <= IDLE;
            data_lfsr_q      <= DATA_SEED;
            bp_lfsr_q        <= BP_SEED;
            beat_cnt_q       <= '0;
            err_cnt_q        <= '0;
            err_q            <= 1'b0;
            first_err_idx_q  <= '0;
            first_err_data_q <= '0;
            done_q           <= 1'b0;
        end else begin
            state_q          <= state_d;
            data_lfsr_q      <= data_lfsr_d;
            bp_lfsr_q        <= bp_lfsr_d;
            beat_cnt_q       <= beat_cnt_d;
            err_cnt_q        <= err_cnt_d;
            err_q            <= err_d;
            first_err_idx_q  <= first_err_idx_d;
            first_err_data_q <= first_err_data_d;
            done_q           <= done_d;
        end
    end

    assign beat_cnt_o       = beat_cnt_q;
    assign err_cnt_o        = err_cnt_q;
    assign err_o            = err_q;
    assign first_err_idx_o  = first_err_idx_q;
    assign first_err_data_o = first_err_data_q;
    assign done_o           = done_q;

endmodule

// File: tb/tb_hwpe_stream_sink_checker.sv
// -----------------------------------------------------------------------------
// Bench for hwpe_stream_sink_checker. Two instances on a 48-bit stream (one
// full lane plus a partial lane): u0 never stalls, u1 stalls about half the
// time. A reference model predicts every output each cycle; predictions go
// into a scoreboard queue and are compared one edge later.
// -----------------------------------------------------------------------------
module tb_hwpe_stream_sink_checker;

    localparam int          DW        = 48;
    localparam int          SW        = DW / 8;
    localparam logic [31:0] DATA_SEED = 32'hACE1_2468;
    localparam logic [15:0] BP_SEED   = 16'hB5A3;

    typedef enum int {M_IDLE, M_RUN, M_DONE} mstate_e;

    typedef struct {
        int          u;
        logic [31:0] beats;
        logic [31:0] errs;
        logic [31:0] fidx;
        logic [DW-1:0] fdata;
        logic        err;
        logic        done;
    } snap_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    // Stimulus, one entry per instance
    logic          en_r    [2];
    logic          clr_r   [2];
    logic          frc_r   [2];
    logic [31:0]   exp_r   [2];
    logic          valid_r [2];
    logic [DW-1:0] data_r  [2];
    logic [SW-1:0] strb_r  [2];

    // DUT outputs
    logic [31:0]   beat_cnt [2];
    logic [31:0]   err_cnt  [2];
    logic          err      [2];
    logic [31:0]   fidx     [2];
    logic [DW-1:0] fdata    [2];
    logic          done     [2];
    logic          rdy      [2];

    hwpe_stream_intf_stream #(.DATA_WIDTH(DW)) if0 ();
    hwpe_stream_intf_stream #(.DATA_WIDTH(DW)) if1 ();

    assign if0.valid = valid_r[0];
    assign if0.data  = data_r[0];
    assign if0.strb  = strb_r[0];
    assign rdy[0]    = if0.ready;
    assign if1.valid = valid_r[1];
    assign if1.data  = data_r[1];
    assign if1.strb  = strb_r[1];
    assign rdy[1]    = if1.ready;

    hwpe_stream_sink_checker #(
        .DATA_WIDTH(DW), .STALL_THRESH(0), .DATA_SEED(DATA_SEED), .BP_SEED(BP_SEED)
    ) u_dut0 (
        .clk_i(clk), .rst_ni(rst_n), .clear_i(clr_r[0]), .enable_i(en_r[0]),
        .force_ready_i(frc_r[0]), .expected_beats_i(exp_r[0]), .data_i(if0),
        .beat_cnt_o(beat_cnt[0]), .err_cnt_o(err_cnt[0]), .err_o(err[0]),
        .first_err_idx_o(fidx[0]), .first_err_data_o(fdata[0]), .done_o(done[0])
    );

    hwpe_stream_sink_checker #(
        .DATA_WIDTH(DW), .STALL_THRESH(128), .DATA_SEED(DATA_SEED), .BP_SEED(BP_SEED)
    ) u_dut1 (
        .clk_i(clk), .rst_ni(rst_n), .clear_i(clr_r[1]), .enable_i(en_r[1]),
        .force_ready_i(frc_r[1]), .expected_beats_i(exp_r[1]), .data_i(if1),
        .beat_cnt_o(beat_cnt[1]), .err_cnt_o(err_cnt[1]), .err_o(err[1]),
        .first_err_idx_o(fidx[1]), .first_err_data_o(fdata[1]), .done_o(done[1])
    );

    // Reference model state
    mstate_e       m_state [2];
    logic [15:0]   m_bp    [2];
    logic [31:0]   m_data  [2];
    logic [31:0]   m_beats [2];
    logic [31:0]   m_errs  [2];
    logic [31:0]   m_fidx  [2];
    logic [DW-1:0] m_fdata [2];
    logic          m_err   [2];

    snap_t sb[$];
    int    n_tests = 0;
    int    n_fail  = 0;
    int    run_cyc [2];
    int    rdy_cyc [2];

    // Source corruption controls
    int bad0      = -1;
    int bad1      = -1;
    int zero_beat = -1;
    bit hide      = 1'b0;
    int gap_pct   = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    function automatic int thresh(input int u);
        return (u == 0) ? 0 : 128;
    endfunction

    function automatic logic [31:0] lfsr32(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
    endfunction

    function automatic logic [15:0] lfsr16(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
    endfunction

    function automatic logic [7:0] exp_byte(input logic [31:0] seed, input int b);
        logic [31:0] w;
        w = seed ^ (32'(b / 4) * 32'h9E37_79B9);
        return 8'(w >> (8 * (b % 4)));
    endfunction

    function automatic logic [DW-1:0] gen_word(input logic [31:0] seed);
        logic [DW-1:0] w;
        w = '0;
        for (int b = 0; b < SW; b++) w[b*8 +: 8] = exp_byte(seed, b);
        return w;
    endfunction

    function automatic bit beat_bad(input logic [31:0] seed, input logic [DW-1:0] d,
                                    input logic [SW-1:0] s);
        for (int b = 0; b < SW; b++)
            if (s[b] && d[b*8 +: 8] != exp_byte(seed, b)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic void model_clear(input int u);
        m_state[u] = M_IDLE;
        m_bp[u]    = BP_SEED;
        m_data[u]  = DATA_SEED;
        m_beats[u] = '0;
        m_errs[u]  = '0;
        m_fidx[u]  = '0;
        m_fdata[u] = '0;
        m_err[u]   = 1'b0;
    endfunction

    function automatic bit model_ready(input int u);
        return (m_state[u] == M_RUN) &&
               ((int'(m_bp[u][7:0]) >= thresh(u)) || frc_r[u]);
    endfunction

    function automatic void step_model(input int u, input bit rd);
        logic [31:0] old;
        bit          hs;
        if (clr_r[u]) begin
            model_clear(u);
            return;
        end
        case (m_state[u])
            M_IDLE: if (en_r[u]) m_state[u] = M_RUN;
            M_RUN: begin
                old = m_beats[u];
                hs  = valid_r[u] && rd;
                if (hs) begin
                    if (beat_bad(m_data[u], data_r[u], strb_r[u])) begin
                        if (m_errs[u] == 0) begin
                            m_fidx[u]  = old;
                            m_fdata[u] = data_r[u];
                        end
                        if (m_errs[u] != 32'hFFFF_FFFF) m_errs[u] = m_errs[u] + 1;
                        m_err[u] = 1'b1;
                    end
                    if (old != 32'hFFFF_FFFF) m_beats[u] = old + 1;
                    m_data[u] = lfsr32(m_data[u]);
                end
                m_bp[u] = lfsr16(m_bp[u]);
                if (exp_r[u] != 0 && ((hs && m_beats[u] == exp_r[u]) || old > exp_r[u]))
                    m_state[u] = M_DONE;
                else if (!en_r[u])
                    m_state[u] = M_IDLE;
            end
            default: ;
        endcase
    endfunction

    // Called at posedge+1 with inputs already driven. Checks ready mid-cycle,
    // steps the model, then compares all outputs just after the next edge.
    task automatic tick();
        bit    mr;
        snap_t s;
        #1;
        for (int u = 0; u < 2; u++) begin
            mr = model_ready(u);
            check($sformatf("u%0d ready", u), rdy[u], mr);
            if (m_state[u] == M_RUN) begin
                run_cyc[u]++;
                if (rdy[u]) rdy_cyc[u]++;
            end
            step_model(u, mr);
            s.u = u; s.beats = m_beats[u]; s.errs = m_errs[u]; s.fidx = m_fidx[u];
            s.fdata = m_fdata[u]; s.err = m_err[u]; s.done = (m_state[u] == M_DONE);
            sb.push_back(s);
        end
        @(posedge clk);
        #1;
        while (sb.size() > 0) begin
            s = sb.pop_front();
            check($sformatf("u%0d beat_cnt", s.u), beat_cnt[s.u], s.beats);
            check($sformatf("u%0d err_cnt", s.u), err_cnt[s.u], s.errs);
            check($sformatf("u%0d err", s.u), err[s.u], s.err);
            check($sformatf("u%0d first_idx", s.u), fidx[s.u], s.fidx);
            check($sformatf("u%0d first_data", s.u), fdata[s.u], s.fdata);
            check($sformatf("u%0d done", s.u), done[s.u], s.done);
        end
    endtask

    // Source: presents the beat the model expects next, with planted faults.
    task automatic drive(input int u);
        logic [DW-1:0] w;
        int            k;
        k          = int'(m_beats[u]);
        w          = gen_word(m_data[u]);
        strb_r[u]  = '1;
        if (k == bad0 || k == bad1) begin
            w[7:0] = ~w[7:0];
            if (hide) strb_r[u][0] = 1'b0;
        end
        if (k == zero_beat) begin
            w         = ~w;
            strb_r[u] = '0;
        end
        data_r[u]  = w;
        valid_r[u] = ($urandom_range(99) >= gap_pct);
    endtask

    task automatic run_beats(input int u, input logic [31:0] n, input int budget);
        int c;
        c = 0;
        while (m_beats[u] < n && m_state[u] != M_DONE && c < budget) begin
            drive(u);
            tick();
            c++;
        end
        check($sformatf("u%0d within budget", u), c < budget, 1'b1);
    endtask

    task automatic pulse_clear(input int u);
        valid_r[u] = 1'b0;
        clr_r[u]   = 1'b1;
        tick();
        clr_r[u]   = 1'b0;
    endtask

    function automatic logic [DW-1:0] word_at(input int idx);
        logic [31:0] s;
        s = DATA_SEED;
        for (int i = 0; i < idx; i++) s = lfsr32(s);
        return gen_word(s);
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int duty;
        for (int u = 0; u < 2; u++) begin
            en_r[u] = 1'b0; clr_r[u] = 1'b0; frc_r[u] = 1'b0; exp_r[u] = '0;
            valid_r[u] = 1'b0; data_r[u] = '0; strb_r[u] = '0;
            run_cyc[u] = 0; rdy_cyc[u] = 0;
            model_clear(u);
        end

        // Reset
        #2 rst_n = 1'b0;
        #1;
        check("reset beat_cnt", beat_cnt[0], 0);
        check("reset done", done[0], 0);
        check("reset ready", rdy[0], 0);
        #19 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1: clean run, no stalls, 16 beats
        exp_r[0] = 32'd16;
        en_r[0]  = 1'b1;
        run_beats(0, 32'hFFFF_FFFF, 200);
        repeat (2) begin drive(0); tick(); end
        check("t1 beats", beat_cnt[0], 16);
        check("t1 errs", err_cnt[0], 0);
        check("t1 done", done[0], 1);
        check("t1 ready low in DONE", rdy[0], 0);
        check("t1 ready every RUN cycle", rdy_cyc[0], run_cyc[0]);

        // 2: beat 5 byte 0 flipped
        pulse_clear(0);
        exp_r[0] = 32'd10;
        bad0     = 5;
        run_beats(0, 32'hFFFF_FFFF, 200);
        tick();
        check("t2 errs", err_cnt[0], 1);
        check("t2 err", err[0], 1);
        check("t2 first idx", fidx[0], 5);
        check("t2 first data", fdata[0], word_at(5) ^ 48'hFF);

        // 3a: same flip hidden by strb
        pulse_clear(0);
        hide = 1'b1;
        run_beats(0, 32'hFFFF_FFFF, 200);
        check("t3a errs", err_cnt[0], 0);
        check("t3a beats", beat_cnt[0], 10);

        // 3b: beats 3 and 7 corrupted, beat 8 all-strb-off garbage
        pulse_clear(0);
        hide      = 1'b0;
        bad0      = 3;
        bad1      = 7;
        zero_beat = 8;
        run_beats(0, 32'hFFFF_FFFF, 200);
        check("t3b errs", err_cnt[0], 2);
        check("t3b first idx", fidx[0], 3);
        check("t3b beats", beat_cnt[0], 10);
        bad0 = -1; bad1 = -1; zero_beat = -1;

        // 4: u1 with 50% stalls, 1000 beats
        exp_r[1] = 32'd1000;
        en_r[1]  = 1'b1;
        run_cyc[1] = 0; rdy_cyc[1] = 0;
        run_beats(1, 32'hFFFF_FFFF, 6000);
        duty = (run_cyc[1] > 0) ? (rdy_cyc[1] * 100) / run_cyc[1] : 0;
        check("t4 duty in 40..60", (duty >= 40 && duty <= 60), 1'b1);
        check("t4 beats", beat_cnt[1], 1000);
        check("t4 errs", err_cnt[1], 0);
        pulse_clear(1);
        frc_r[1] = 1'b1;
        exp_r[1] = 32'd50;
        run_cyc[1] = 0; rdy_cyc[1] = 0;
        run_beats(1, 32'hFFFF_FFFF, 200);
        check("t4 forced ready every RUN cycle", rdy_cyc[1], run_cyc[1]);
        check("t4 forced beats", beat_cnt[1], 50);
        frc_r[1] = 1'b0;
        en_r[1]  = 1'b0;

        // 5: enable drop on the 7th handshake, resume, clear on a handshake
        pulse_clear(0);
        exp_r[0] = 32'd0;
        gap_pct  = 30;
        run_beats(0, 32'd6, 200);
        gap_pct  = 0;
        drive(0);
        en_r[0] = 1'b0;
        tick();
        check("t5 beat counted on enable drop", beat_cnt[0], 7);
        repeat (5) begin drive(0); tick(); end
        check("t5 beats hold in IDLE", beat_cnt[0], 7);
        en_r[0] = 1'b1;
        gap_pct = 30;
        run_beats(0, 32'd20, 300);
        check("t5 beats resumed", beat_cnt[0], 20);
        check("t5 errs resumed", err_cnt[0], 0);
        gap_pct  = 0;
        drive(0);
        clr_r[0] = 1'b1;
        tick();
        clr_r[0] = 1'b0;
        check("t5 clear beats", beat_cnt[0], 0);
        check("t5 clear errs", err_cnt[0], 0);
        check("t5 clear ready", rdy[0], 0);
        run_beats(0, 32'd5, 100);
        check("t5 restart from seed", err_cnt[0], 0);
        exp_r[0]   = 32'd3;
        valid_r[0] = 1'b0;
        tick();
        check("t5 target lowered -> done", done[0], 1);

        // 6: asynchronous reset mid-run with errors pending
        pulse_clear(0);
        exp_r[0] = 32'd0;
        bad0     = 1;
        run_beats(0, 32'd4, 100);
        bad0     = -1;
        check("t6 errs before reset", err_cnt[0], 1);
        #2 rst_n = 1'b0;
        #1;
        check("t6 async beats", beat_cnt[0], 0);
        check("t6 async errs", err_cnt[0], 0);
        check("t6 async err", err[0], 0);
        check("t6 async first idx", fidx[0], 0);
        check("t6 async first data", fdata[0], 0);
        check("t6 async ready", rdy[0], 0);
        check("t6 async u1 done", done[1], 0);
        model_clear(0);
        model_clear(1);
        en_r[0] = 1'b0;
        valid_r[0] = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        tick();
        check("t6 idle ready after reset", rdy[0], 0);
        en_r[0] = 1'b1;
        tick();
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
